multichannel_serializer: RTL and testbench

MULTICHANNEL_SERIALIZER -- requirements
Module: multichannel_serializer

---
 rtl/multichannel_serializer.sv | 141 ++++++++++++++
 tb/tb_multichannel_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_serializer.sv
// multichannel_serializer
//   Accepts one frame of CHANNELS packed words over a valid/ready handshake.
//   It sends the frame as a serial stream with a divided bit clock.
//   Each word is left-justified in a SLOT_WIDTH slot, with zero padding below it.
//   Slots go out in channel order 0..CHANNELS-1, and each slot goes MSB first.
//   Optional feature macro: MCSER_PARITY_EN. When it is defined, one extra bit
//   period is appended after the last slot. That bit carries even parity of the frame.
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   s_tdata    : CHANNELS*BIT_DEPTH packed words, channel 0 in the LSBs
//   s_tvalid   : frame word valid
//   s_tready   : block accepts a frame (IDLE and not in reset)
//   clk_out    : serial bit clock, low then high for CLK_DIV cycles each
//   data_out   : serial data, changes at bit-period start
//   frame_sync : high during the first bit period of a frame
//   busy       : frame transmission in progress
module multichannel_serializer #(
    parameter int CHANNELS   = 2,
    parameter int BIT_DEPTH  = 13,
    parameter int SLOT_WIDTH = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*BIT_DEPTH-1:0] s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic                          clk_out,
    output logic                          data_out,
    output logic                          frame_sync,
    output logic                          busy
);

    localparam int NBITS = CHANNELS * SLOT_WIDTH;
    localparam int CNT_W = $clog2(NBITS + 2);
    localparam int DIV_W = $clog2(2 * CLK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef MCSER_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NBITS-1:0]   shreg;
    logic [NBITS-1:0]   frame;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic               bit_end;
    logic               last_bit;
`ifdef MCSER_PARITY_EN
    logic               parity_bit;
`endif

    // Channel 0 lands in the top slot, so a plain left shift sends channels in order.
    always_comb begin
        frame = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            frame[(CHANNELS - 1 - ch) * SLOT_WIDTH +: SLOT_WIDTH] =
                SLOT_WIDTH'(s_tdata[ch * BIT_DEPTH +: BIT_DEPTH]) << (SLOT_WIDTH - BIT_DEPTH);
        end
    end

    assign bit_end  = (div_cnt == DIV_W'(2 * CLK_DIV - 1));
    assign last_bit = (bit_cnt == CNT_W'(NBITS - 1));

    always_comb begin
        state_next = state;
        s_tready   = 1'b0;
        busy       = 1'b0;
        clk_out    = 1'b0;
        data_out   = 1'b0;
        frame_sync = 1'b0;
        case (state)
            IDLE: begin
                s_tready = !rst;
                if (s_tvalid && !rst)
                    state_next = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                clk_out    = (div_cnt >= DIV_W'(CLK_DIV));
                data_out   = shreg[NBITS-1];
                frame_sync = (bit_cnt == '0);
                if (bit_end && last_bit) begin
`ifdef MCSER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef MCSER_PARITY_EN
            PARITY: begin
                busy     = 1'b1;
                clk_out  = (div_cnt >= DIV_W'(CLK_DIV));
                data_out = parity_bit;
                if (bit_end)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
`ifdef MCSER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                if (s_tvalid) begin
                    shreg <= frame;
`ifdef MCSER_PARITY_EN
                    // Padding bits are zero, so the parity of the slotted frame equals the parity of the data.
                    parity_bit <= ^frame;
`endif
                end
            end else begin
                div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
                if (bit_end) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multichannel_serializer.sv
// Self-checking bench for multichannel_serializer.
// The expected output is computed from frame rules: slot index, bit position and parity.
// The bench also checks a second instance with CHANNELS=1, BIT_DEPTH=16, SLOT_WIDTH=16, CLK_DIV=1.
module tb_multichannel_serializer;

    localparam int CH = 2;
    localparam int BD = 13;
    localparam int SW = 16;
    localparam int CD = 2;
    localparam int NB = CH * SW;
`ifdef MCSER_PARITY_EN
    localparam int FB  = NB + 1;
    localparam int FB1 = 17;
`else
    localparam int FB  = NB;
    localparam int FB1 = 16;
`endif
    localparam int FC  = FB * 2 * CD;
    localparam int FC1 = FB1 * 2;

    localparam logic [4:0] IDLE_EXP = 5'b01000;
    localparam logic [4:0] ZERO_EXP = 5'b00000;

    logic clk = 1'b0;
    logic rst;
    logic [CH*BD-1:0] s_tdata;
    logic s_tvalid, s_tready, clk_out, data_out, frame_sync, busy;
    logic [15:0] s1_tdata;
    logic s1_tvalid, s1_tready, s1_clk_out, s1_data_out, s1_frame_sync, s1_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multichannel_serializer #(.CHANNELS(CH), .BIT_DEPTH(BD), .SLOT_WIDTH(SW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .clk_out(clk_out), .data_out(data_out), .frame_sync(frame_sync), .busy(busy)
    );

    multichannel_serializer #(.CHANNELS(1), .BIT_DEPTH(16), .SLOT_WIDTH(16), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .s_tdata(s1_tdata), .s_tvalid(s1_tvalid), .s_tready(s1_tready),
        .clk_out(s1_clk_out), .data_out(s1_data_out), .frame_sync(s1_frame_sync), .busy(s1_busy)
    );

    function automatic logic [4:0] obs();
        return {busy, s_tready, clk_out, data_out, frame_sync};
    endfunction

    function automatic logic [4:0] obs1();
        return {s1_busy, s1_tready, s1_clk_out, s1_data_out, s1_frame_sync};
    endfunction

    // Frame bit k: take slot k/SW at position k%SW, counting from the slot MSB.
    // A position at or beyond BD is padding.
    function automatic logic ref_bit(input logic [CH*BD-1:0] d, input int k);
        int slot = k / SW;
        int pos  = k % SW;
        if (pos >= BD) return 1'b0;
        return d[slot * BD + (BD - 1 - pos)];
    endfunction

    function automatic logic ref_parity(input logic [CH*BD-1:0] d);
        logic p = 1'b0;
        for (int k = 0; k < NB; k++) p = p ^ ref_bit(d, k);
        return p;
    endfunction

    // Expected {busy, s_tready, clk_out, data_out, frame_sync} on cycle c of a frame.
    function automatic logic [4:0] frame_exp(input logic [CH*BD-1:0] d, input int c);
        int k = c / (2 * CD);
        logic b;
        if (k < NB) b = ref_bit(d, k);
        else        b = ref_parity(d);
        return {1'b1, 1'b0, ((c % (2 * CD)) >= CD), b, (k == 0)};
    endfunction

    task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (busy,tready,clk_out,data_out,fsync)", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks frame cycles c0..c1-1. The caller must already be sitting on cycle c0.
    task automatic check_frame(input logic [CH*BD-1:0] d, input int c0, input int c1, input string tag);
        for (int c = c0; c < c1; c++) begin
            if (c != c0) tick();
            check($sformatf("%s_c%0d", tag, c), obs(), frame_exp(d, c));
        end
    endtask

    logic [CH*BD-1:0] w [3];
    logic [CH*BD-1:0] a, b;
    logic [15:0] d1;

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s1_tvalid = 1'b0;
        s1_tdata = '0;
        repeat (3) tick();
        check("reset", obs(), ZERO_EXP);
        check("reset_dut1", obs1(), ZERO_EXP);
        rst = 1'b0;
        tick();
        check("after_reset", obs(), IDLE_EXP);

        // Directed frame: ch0 = 13'h1ABC, ch1 = 13'h0001.
        a = {13'h0001, 13'h1ABC};
        s_tdata = a;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_frame(a, 0, FC, "dir");
        tick();
        check("dir_idle", obs(), IDLE_EXP);
        tick();
        check("dir_idle2", obs(), IDLE_EXP);

        // Back-to-back: s_tvalid is held high for three frames.
        // The next word is presented while the current frame is busy.
        for (int i = 0; i < 3; i++) w[i] = CH*BD'($urandom);
        s_tdata = w[0];
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) s_tdata = w[i+1];
            else       s_tvalid = 1'b0;
            check_frame(w[i], 0, FC, $sformatf("b2b%0d", i));
            tick();
            check($sformatf("b2b_gap%0d", i), obs(), IDLE_EXP);
        end
        repeat (3) begin
            tick();
            check("b2b_noextra", obs(), IDLE_EXP);
        end

        // s_tvalid rises mid-frame and is held; the word must be sent exactly once.
        a = CH*BD'($urandom);
        b = CH*BD'($urandom);
        s_tdata = a;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_frame(a, 0, 50, "held_a");
        s_tdata = b;
        s_tvalid = 1'b1;
        tick();
        check_frame(a, 50, FC, "held_a");
        tick();
        check("held_gap", obs(), IDLE_EXP);
        tick();
        s_tvalid = 1'b0;
        check_frame(b, 0, FC, "held_b");
        tick();
        check("held_idle", obs(), IDLE_EXP);
        tick();
        check("held_noextra", obs(), IDLE_EXP);

        // Reset asserted at the start of bit 10 aborts the frame.
        a = CH*BD'($urandom);
        s_tdata = a;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_frame(a, 0, 10 * 2 * CD + 1, "abort");
        rst = 1'b1;
        tick();
        check("abort_zero", obs(), ZERO_EXP);
        tick();
        check("abort_zero2", obs(), ZERO_EXP);
        rst = 1'b0;
        tick();
        check("abort_ready", obs(), IDLE_EXP);
        a = CH*BD'($urandom);
        s_tdata = a;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_frame(a, 0, FC, "post_abort");
        tick();
        check("post_abort_idle", obs(), IDLE_EXP);

        // Parity patterns: seven ones and six ones in ch0.
        a = {13'h0000, 13'h007F};
        s_tdata = a;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_frame(a, 0, FC, "par7");
        tick();
        check("par7_idle", obs(), IDLE_EXP);
        a = {13'h0000, 13'h003F};
        s_tdata = a;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_frame(a, 0, FC, "par6");
        tick();
        check("par6_idle", obs(), IDLE_EXP);

        // Random frames separated by random idle gaps.
        for (int i = 0; i < 4; i++) begin
            a = CH*BD'($urandom);
            s_tdata = a;
            s_tvalid = 1'b1;
            tick();
            s_tvalid = 1'b0;
            check_frame(a, 0, FC, $sformatf("rnd%0d", i));
            repeat ($urandom_range(1, 3)) begin
                tick();
                check("rnd_idle", obs(), IDLE_EXP);
            end
        end

        // Single-channel instance, CLK_DIV=1, data 16'h8001.
        check("dut1_idle", obs1(), IDLE_EXP);
        d1 = 16'h8001;
        s1_tdata = d1;
        s1_tvalid = 1'b1;
        tick();
        s1_tvalid = 1'b0;
        for (int c = 0; c < FC1; c++) begin
            logic bit1;
            if (c > 0) tick();
            bit1 = (c / 2 < 16) ? d1[15 - c / 2] : ^d1;
            check($sformatf("dut1_c%0d", c), obs1(), {1'b1, 1'b0, logic'(c % 2), bit1, logic'(c < 2)});
        end
        tick();
        check("dut1_end", obs1(), IDLE_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
